// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared types and constants for the 5-stage pipeline hazard controller.
//   state_t          : controller FSM state (RUN, MEM_WAIT)
//   WAIT_MAX_DEFAULT : default bound on data-memory wait cycles
//   REG_ZERO         : hard-wired zero register, never a real dependency
//   reg_hit()        : true when a producer destination feeds a consumer source
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam int WAIT_MAX_DEFAULT = 16;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Writes to r0 are discarded by the register file, so they never create a hazard.
  function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/hz_perf_cnt.sv
// hz_perf_cnt
// Free-running hazard performance counters, both wrapping modulo 2^32.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   stall_inc       : a memory-hold or load-use cycle occurred
//   flush_inc       : an IF/ID or ID/EX flush was issued this cycle
//   stall_cycles    : accumulated stall cycles
//   flush_events    : accumulated flush cycles
module hz_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_inc,
  input  logic        flush_inc,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 32'd0;
      flush_events <= 32'd0;
    end else begin
      if (stall_inc) stall_cycles <= stall_cycles + 32'd1;
      if (flush_inc) flush_events <= flush_events + 32'd1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Sequencing controller for the 5-stage core: stage load enables and bubble
// flushes for PC, IF_ID, ID_EX, EX_MEM, MEM_WB. Inserts a load-use bubble,
// squashes wrong-path fetches on taken branches / jumps, freezes the pipe on
// an outstanding data-memory access and flags a sticky bus error on timeout.
//
// Build option: HAZ_PERF_CNT_EN enables the stall/flush performance counters;
// without it stall_cycles and flush_events are tied to 0.
//
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   id_rs, id_rt, id_uses_rt     : source operands of the ID instruction
//   ex_rd, ex_regw, ex_mem2r     : destination / kind of the EX instruction
//   ex_branch_taken, id_jump     : control-flow redirects
//   dm_req, dm_ready             : data-memory handshake of the MEM stage
//   pc_wr .. mem_wb_wr           : stage register load enables
//   if_id_flush, id_ex_flush,
//   mem_wb_flush                 : load a bubble into the stage register
//   bus_err                      : sticky memory timeout flag
//   stall_cycles, flush_events   : performance counters
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow; a blocked memory access enters MEM_WAIT
// MEM_WAIT | pipe frozen waiting for dm_ready; wait_cnt bounds the wait
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEFAULT  // legal range 2..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regw,
  input  logic        ex_mem2r,
  input  logic        ex_branch_taken,
  input  logic        id_jump,
  input  logic        dm_req,
  input  logic        dm_ready,
  output logic        pc_wr,
  output logic        if_id_wr,
  output logic        id_ex_wr,
  output logic        ex_mem_wr,
  output logic        mem_wb_wr,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mem_wb_flush,
  output logic        bus_err,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       timeout;
  logic       mem_hold;
  logic       load_use;

  assign timeout  = (state == MEM_WAIT) && (wait_cnt == WAIT_LAST);
  assign mem_hold = dm_req && !dm_ready && !timeout;
  assign load_use = ex_mem2r && ex_regw &&
                    (reg_hit(ex_rd, id_rs) || (id_uses_rt && reg_hit(ex_rd, id_rt)));

  always_comb begin
    pc_wr        = 1'b1;
    if_id_wr     = 1'b1;
    id_ex_wr     = 1'b1;
    ex_mem_wr    = 1'b1;
    mem_wb_wr    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;

    if (mem_hold) begin
      // Front of the pipe freezes; WB keeps clocking but retires a bubble so
      // the stalled MEM instruction is not written back twice.
      pc_wr        = 1'b0;
      if_id_wr     = 1'b0;
      id_ex_wr     = 1'b0;
      ex_mem_wr    = 1'b0;
      mem_wb_flush = 1'b1;
    end else begin
      // A timed-out access never completed, so its writeback is squashed.
      if (timeout) mem_wb_flush = 1'b1;

      if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use && !timeout) begin
        pc_wr       = 1'b0;
        if_id_wr    = 1'b0;
        id_ex_flush = 1'b1;
      end else if (id_jump) begin
        if_id_flush = 1'b1;
      end
    end

    if (rst) begin
      pc_wr        = 1'b0;
      if_id_wr     = 1'b0;
      id_ex_wr     = 1'b0;
      ex_mem_wr    = 1'b0;
      mem_wb_wr    = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      mem_wb_flush = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
      bus_err  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (dm_req && !dm_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd0;
          end
        end
        MEM_WAIT: begin
          if (timeout) begin
            bus_err <= 1'b1;
            state   <= RUN;
          end else if (dm_ready) begin
            state <= RUN;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = mem_hold || load_use;
  assign flush_inc = if_id_flush || id_ex_flush;

  hz_perf_cnt u_perf (
    .clk          (clk),
    .rst          (rst),
    .stall_inc    (stall_inc),
    .flush_inc    (flush_inc),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );
`else
  assign stall_cycles = 32'd0;
  assign flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int WAIT_MAX = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rt, ex_regw, ex_mem2r, ex_branch_taken, id_jump;
  logic        dm_req, dm_ready;
  logic        pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr;
  logic        if_id_flush, id_ex_flush, mem_wb_flush, bus_err;
  logic [31:0] stall_cycles, flush_events;

  int n_vec = 0;
  int n_err = 0;

  pipe_hazard_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_regw(ex_regw), .ex_mem2r(ex_mem2r),
    .ex_branch_taken(ex_branch_taken), .id_jump(id_jump),
    .dm_req(dm_req), .dm_ready(dm_ready),
    .pc_wr(pc_wr), .if_id_wr(if_id_wr), .id_ex_wr(id_ex_wr),
    .ex_mem_wr(ex_mem_wr), .mem_wb_wr(mem_wb_wr),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush), .bus_err(bus_err),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks only "are we waiting, how long have we waited, has a timeout happened"
  // plus running totals; outputs are derived from the priority rules each cycle.
  bit          m_waiting;
  int          m_waited;
  bit          m_err;
  logic [31:0] m_stall, m_flush;

  function automatic logic [7:0] outs(input logic a, b, c, d, e, f, g, h);
    return {a, b, c, d, e, f, g, h};
  endfunction

  always @(negedge clk) begin
    logic       lu, to, hold, br, jmp;
    logic [7:0] exp_v, act_v;
    act_v = outs(pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr,
                 if_id_flush, id_ex_flush, mem_wb_flush);
    if (rst) begin
      check("reset_outs", {24'd0, act_v}, 32'd0);
      check("reset_bus_err", {31'd0, bus_err}, 32'd0);
      check("reset_stall", stall_cycles, 32'd0);
      check("reset_flush", flush_events, 32'd0);
      m_waiting = 0; m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0;
    end else begin
      br  = ex_branch_taken;
      jmp = id_jump;
      lu  = ex_mem2r && ex_regw && ex_rd != 5'd0 &&
            (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
      to   = m_waiting && (m_waited == WAIT_MAX - 1);
      hold = dm_req && !dm_ready && !to;
      if (hold)    exp_v = outs(0, 0, 0, 0, 1, 0, 0, 1);
      else if (to) exp_v = outs(1, 1, 1, 1, 1, br | jmp, br, 1);
      else if (br) exp_v = outs(1, 1, 1, 1, 1, 1, 1, 0);
      else if (lu) exp_v = outs(0, 0, 1, 1, 1, 0, 1, 0);
      else if (jmp) exp_v = outs(1, 1, 1, 1, 1, 1, 0, 0);
      else         exp_v = outs(1, 1, 1, 1, 1, 0, 0, 0);
      check("stage_ctrl", {24'd0, act_v}, {24'd0, exp_v});
      check("bus_err", {31'd0, bus_err}, {31'd0, m_err});
`ifdef HAZ_PERF_CNT_EN
      check("stall_cycles", stall_cycles, m_stall);
      check("flush_events", flush_events, m_flush);
`else
      check("stall_cycles", stall_cycles, 32'd0);
      check("flush_events", flush_events, 32'd0);
`endif
      if (hold || lu) m_stall = m_stall + 1;
      if (exp_v[2] || exp_v[1]) m_flush = m_flush + 1;
      if (to) begin
        m_err = 1; m_waiting = 0;
      end else if (!m_waiting) begin
        if (dm_req && !dm_ready) begin m_waiting = 1; m_waited = 0; end
      end else if (dm_ready) begin
        m_waiting = 0;
      end else begin
        m_waited++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 0; ex_rd = 5'd3;
    ex_regw = 0; ex_mem2r = 0; ex_branch_taken = 0; id_jump = 0;
    dm_req = 0; dm_ready = 0;
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] rd, input logic [4:0] rs,
                      input logic [4:0] rt, input logic uses_rt);
    ex_mem2r = 1; ex_regw = 1; ex_rd = rd; id_rs = rs; id_rt = rt; id_uses_rt = uses_rt;
  endtask

  initial begin
    int k;
    bit found;
    idle();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check("lit_rst_pc_wr", {31'd0, pc_wr}, 32'd0);
    rst = 0;

    // Perf section: idle, 1 load-use, idle, 3-cycle memory wait, release.
    cyc(); idle(); #1;
    check("lit_idle_pc_wr", {31'd0, pc_wr}, 32'd1);
    cyc(); load(5'd8, 5'd8, 5'd4, 0); #1;
    check("lit_lu_pc_wr", {31'd0, pc_wr}, 32'd0);
    check("lit_lu_if_id_wr", {31'd0, if_id_wr}, 32'd0);
    check("lit_lu_id_ex_flush", {31'd0, id_ex_flush}, 32'd1);
    check("lit_lu_id_ex_wr", {31'd0, id_ex_wr}, 32'd1);
    cyc(); idle();
    for (int i = 0; i < 3; i++) begin
      cyc(); dm_req = 1; dm_ready = 0; #1;
      check("lit_hold_mem_wb_flush", {31'd0, mem_wb_flush}, 32'd1);
      check("lit_hold_pc_wr", {31'd0, pc_wr}, 32'd0);
    end
    cyc(); dm_req = 1; dm_ready = 1; #1;
    check("lit_release_pc_wr", {31'd0, pc_wr}, 32'd1);
    check("lit_release_mem_wb_flush", {31'd0, mem_wb_flush}, 32'd0);
    cyc(); idle(); #1;
`ifdef HAZ_PERF_CNT_EN
    check("lit_stall_cycles", stall_cycles, 32'd4);
    check("lit_flush_events", flush_events, 32'd1);
`else
    check("lit_stall_cycles", stall_cycles, 32'd0);
`endif

    // Load-use variants.
    cyc(); load(5'd8, 5'd1, 5'd8, 1); #1;
    check("lit_lu_rt_pc_wr", {31'd0, pc_wr}, 32'd0);
    cyc(); load(5'd8, 5'd1, 5'd8, 0); #1;
    check("lit_rt_unused_pc_wr", {31'd0, pc_wr}, 32'd1);
    cyc(); load(5'd0, 5'd0, 5'd0, 1); #1;
    check("lit_r0_pc_wr", {31'd0, pc_wr}, 32'd1);
    cyc(); load(5'd8, 5'd8, 5'd4, 0); ex_mem2r = 0; #1;
    check("lit_alu_no_stall", {31'd0, pc_wr}, 32'd1);

    // Taken branch with coincident load-use and jump.
    cyc(); load(5'd8, 5'd8, 5'd4, 0); ex_branch_taken = 1; id_jump = 1; #1;
    check("lit_br_if_id_flush", {31'd0, if_id_flush}, 32'd1);
    check("lit_br_id_ex_flush", {31'd0, id_ex_flush}, 32'd1);
    check("lit_br_pc_wr", {31'd0, pc_wr}, 32'd1);

    // Jump alone.
    cyc(); idle(); id_jump = 1; #1;
    check("lit_jmp_if_id_flush", {31'd0, if_id_flush}, 32'd1);
    check("lit_jmp_id_ex_flush", {31'd0, id_ex_flush}, 32'd0);

    // Branch held in EX during a memory wait: flushes only on release.
    cyc(); idle();
    for (int i = 0; i < 3; i++) begin
      cyc(); dm_req = 1; ex_branch_taken = 1; #1;
      check("lit_wait_br_no_flush", {31'd0, if_id_flush}, 32'd0);
    end
    cyc(); dm_ready = 1; #1;
    check("lit_wait_br_release_if", {31'd0, if_id_flush}, 32'd1);
    check("lit_wait_br_release_idex", {31'd0, id_ex_flush}, 32'd1);

    // Timeout: dm_ready never rises.
    cyc(); idle();
    found = 0;
    k = 0;
    for (int i = 1; i <= 40 && !found; i++) begin
      cyc(); dm_req = 1; dm_ready = 0; #1;
      if (pc_wr && mem_wb_flush) begin
        found = 1; k = i;
      end
    end
    check("timeout_found", {31'd0, found}, 32'd1);
    check("timeout_cycle", k, WAIT_MAX + 1);
    cyc(); idle(); #1;
    check("lit_bus_err_set", {31'd0, bus_err}, 32'd1);
    repeat (3) cyc();
    check("lit_bus_err_sticky", {31'd0, bus_err}, 32'd1);

    // Asynchronous reset in the middle of a wait.
    for (int i = 0; i < 3; i++) begin
      cyc(); dm_req = 1; dm_ready = 0;
    end
    #1;
    rst = 1;
    #1;
    check("lit_arst_bus_err", {31'd0, bus_err}, 32'd0);
    check("lit_arst_mem_wb_flush", {31'd0, mem_wb_flush}, 32'd0);
    check("lit_arst_stall", stall_cycles, 32'd0);
    @(negedge clk);
    cyc(); rst = 0; idle();
    // Fresh wait after reset must behave like a new wait from RUN.
    for (int i = 0; i < 2; i++) begin
      cyc(); dm_req = 1; dm_ready = 0;
    end
    cyc(); dm_ready = 1;
    cyc(); idle();
    repeat (2) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
